user_rom_streamer: RTL



---
 rtl/user_rom_streamer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/user_rom_streamer.sv
// user_rom_streamer: pipelined OBI reader that streams consecutive ROM words through a
// small FIFO. Optional running checksum enabled by USER_ROM_STREAMER_CHECKSUM_EN.

package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rid;
    logic        err;
    logic        r_optional;
  } obi_rsp_t;
endpackage

// state | meaning
// IDLE  | waiting for start; late responses ignored
// ISSUE | issuing reads while credit and remaining words allow
// DRAIN | no new reads; wait for outstanding responses and an empty FIFO
module user_rom_streamer #(
  parameter obi_pkg::obi_cfg_t ObiCfg         = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t      = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t      = obi_pkg::obi_rsp_t,
  parameter int unsigned       MaxOutstanding = 2,
  parameter int unsigned       FifoDepth      = 4,
  parameter int unsigned       CntWidth       = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]         num_words_i,
  output obi_req_t                    obi_req_o,
  input  obi_rsp_t                    obi_rsp_i,
  output logic [31:0]                 stream_data_o,
  output logic                        stream_valid_o,
  input  logic                        stream_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 checksum_o
);
  localparam int unsigned AW = ObiCfg.AddrWidth;
  localparam int unsigned PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CW = $clog2(FifoDepth) + 2;
  localparam logic [CW-1:0] MAX_OUT = CW'(MaxOutstanding);
  localparam logic [CW-1:0] DEPTH   = CW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_addr;
  logic [CntWidth-1:0] r_remaining;
  logic [CW-1:0]       r_outstanding, r_count;
  logic                r_req, r_err, r_done;
  logic [31:0]         r_mem [FifoDepth];
  logic [PW-1:0]       r_wptr, r_rptr;

  logic                w_start_idle, w_accept, w_gnt, w_rvalid, w_rsp_err;
  logic                w_push, w_pop, w_req_nxt, w_done_nxt, w_unused;
  logic [CntWidth-1:0] w_rem_nxt;
  logic [CW-1:0]       w_out_nxt, w_cnt_nxt;

  assign w_start_idle = start_i && (r_state == IDLE);
  assign w_accept     = w_start_idle && (num_words_i != '0);
  assign w_gnt        = r_req && obi_rsp_i.gnt;
  assign w_rvalid     = obi_rsp_i.rvalid && (r_state != IDLE);
  assign w_rsp_err    = w_rvalid && obi_rsp_i.err;
  // after the first error every remaining response is dropped
  assign w_push       = w_rvalid && !obi_rsp_i.err && !r_err;
  assign w_pop        = stream_valid_o && stream_ready_i;

  assign w_rem_nxt = w_accept ? num_words_i : r_remaining - CntWidth'(w_gnt);
  assign w_out_nxt = r_outstanding + CW'(w_gnt) - CW'(w_rvalid);
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_req_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE;
        else if (w_start_idle) w_done_nxt = 1'b1;
      end
      ISSUE: begin
        if (w_rsp_err || (w_gnt && r_remaining == CntWidth'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_req && r_outstanding == '0 && r_count == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // credit uses next-cycle counts so a granted request always has a FIFO slot
    if (r_req && !obi_rsp_i.gnt) begin
      w_req_nxt = 1'b1;
    end else if (w_state_nxt == ISSUE && w_rem_nxt != '0 && w_out_nxt < MAX_OUT &&
                 (w_out_nxt + w_cnt_nxt) < DEPTH) begin
      w_req_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_req         <= 1'b0;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_remaining   <= w_rem_nxt;
      r_outstanding <= w_out_nxt;
      r_req         <= w_req_nxt;
      r_done        <= w_done_nxt;
      if (w_accept) r_addr <= {base_addr_i[AW-1:2], 2'b00};
      else if (w_gnt) r_addr <= r_addr + AW'(4);
      if (w_start_idle) r_err <= 1'b0;
      else if (w_rsp_err) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      assert (!(w_push && !w_pop && r_count == DEPTH));
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= obi_rsp_i.rdata;
  end

  assign stream_data_o  = r_mem[r_rptr];
  assign stream_valid_o = (r_count != '0);
  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign w_unused       = ^{obi_rsp_i.rid, obi_rsp_i.r_optional, base_addr_i[1:0]};

  always_comb begin
    obi_req_o      = '0;
    obi_req_o.req  = r_req;
    obi_req_o.be   = 4'hF;
    obi_req_o.addr = 32'(r_addr);
  end

`ifdef USER_ROM_STREAMER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_checksum <= '0;
    else if (w_start_idle) r_checksum <= '0;
    else if (w_push) r_checksum <= r_checksum + obi_rsp_i.rdata;
  end

  assign checksum_o = r_checksum;
`else
  assign checksum_o = '0;
`endif

endmodule
